sram_xfer_req: RTL and testbench

Transfer requester for the SRAM DMA engine: accepts a read/write command from the USB endpoint logic, validates the length, and raises the DMA engine's level-sensitive `xfer_read`/`xfer_write` request. It then waits for the engine's `xfer_done` rising edge, with a timeout, and returns a one-entry status response. It sits between the USB endpoint command logic and the SRAM DMA block, and drives the other end of its `xfer_*` handshake.

---
 rtl/sram_xfer_req.sv | 146 ++++++++++++++
 tb/tb_sram_xfer_req.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sram_xfer_req.sv
`timescale 1ns/1ps
// sram_xfer_req: USB endpoint command -> SRAM DMA request handshake.
// Ports: cmd_* (command in), xfer_* (DMA request/done), rsp_* (status out), busy.
module sram_xfer_req #(
  parameter int              HOLD_CYCLES = 4,
  parameter int              TW          = 16,
  parameter logic [TW-1:0]   TIMEOUT     = 16'd8191
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [9:0] cmd_len,
  output logic       xfer_read,
  output logic       xfer_write,
  output logic [9:0] xfer_len,
  input  logic       xfer_done,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_err,
  output logic       busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      err_q, err_d;
  logic            dir_q;
  logic [9:0]      len_q;
  logic [HW-1:0]   hold_q;
  logic [TW-1:0]   tmo_q;
  logic            d1, d2;
  logic            seen_q;

  logic accept;
  logic len_ok;
  logic done_edge;
  logic hold_last;
  logic tmo_hit;
  logic active;

  assign accept    = cmd_valid & (state_q == IDLE);
  assign len_ok    = ~cmd_len[0] & (cmd_len >= 10'd2)
                   & (cmd_len <= 10'd512);
  assign done_edge = d1 & ~d2;
  assign hold_last = hold_q == HW'(HOLD_CYCLES - 1);
  // >= so a counter that saturated in REQ still terminates in WAIT
  assign tmo_hit   = tmo_q >= (TIMEOUT - TW'(1));
  assign active    = (state_q == REQ) | (state_q == WAIT);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (len_ok) begin
            state_d = REQ;
            err_d   = ERR_OK;
          end else begin
            state_d = RESP;
            err_d   = ERR_LEN;
          end
        end
      end
      REQ: begin
        // An edge landing in the final hold cycle must not be lost
        if (hold_last) begin
          if (seen_q | done_edge) begin
            state_d = RESP;
            err_d   = ERR_OK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (done_edge) begin
          state_d = RESP;
          err_d   = ERR_OK;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = ERR_TMO;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q   <= ERR_OK;
      dir_q   <= 1'b0;
      len_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      d1      <= 1'b0;
      d2      <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      d1      <= xfer_done;
      d2      <= d1;
      if (accept) begin
        dir_q  <= cmd_dir;
        len_q  <= cmd_len;
        hold_q <= '0;
        tmo_q  <= '0;
        seen_q <= 1'b0;
      end else begin
        if (state_q == REQ && !hold_last)
          hold_q <= hold_q + HW'(1);
        if (active && !(&tmo_q))
          tmo_q <= tmo_q + TW'(1);
        if (active && done_edge)
          seen_q <= 1'b1;
      end
    end
  end

  assign cmd_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign rsp_valid  = state_q == RESP;
  assign rsp_err    = err_q;
  assign xfer_read  = (state_q == REQ) & ~dir_q;
  assign xfer_write = (state_q == REQ) & dir_q;
  assign xfer_len   = len_q;

endmodule

// File: tb/tb_sram_xfer_req.sv
`timescale 1ns/1ps
// tb_sram_xfer_req: randomized bench for sram_xfer_req.
// Transaction-level model predicts response cycle, status and request pulses.
module tb_sram_xfer_req;

  localparam int H = 4;
  localparam int T = 8191;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [9:0] cmd_len;
  logic       xfer_read;
  logic       xfer_write;
  logic [9:0] xfer_len;
  logic       xfer_done;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_err;
  logic       busy;

  int n_tests;
  int n_fail;

  sram_xfer_req dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_len    (cmd_len),
    .xfer_read  (xfer_read),
    .xfer_write (xfer_write),
    .xfer_len   (xfer_len),
    .xfer_done  (xfer_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // dly: cycles after accept at which the DMA raises done (-1 = never)
  task automatic run_xfer(input logic dir, input int len,
                          input int dly, input bit stale,
                          input int rdy_dly, input string tag);
    int         n_rd, n_wr, len_bad, busy_bad, hold_bad;
    int         rk, exp_k, e_rel;
    bit         legal;
    logic [1:0] exp_err, got_err;
    logic [9:0] l10;
    n_rd = 0; n_wr = 0; len_bad = 0; busy_bad = 0; hold_bad = 0;
    rk = -1; got_err = 2'b11;
    l10 = len[9:0];
    legal = (len % 2 == 0) && len >= 2 && len <= 512;
    e_rel = dly + 1;
    if (!legal) begin
      exp_k = 0; exp_err = 2'b01;
    end else if (dly >= 0 && e_rel <= T - 1) begin
      exp_err = 2'b00;
      exp_k = (e_rel + 1 > H) ? e_rel + 1 : H;
    end else begin
      exp_err = 2'b10; exp_k = T;
    end
    if (stale) begin
      xfer_done = 1'b1;
      repeat (5) @(negedge clk);
    end
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_len = l10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k <= T + 10 && rk < 0; k++) begin
      if (xfer_read) n_rd++;
      if (xfer_write) n_wr++;
      if (xfer_len !== l10) len_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (rsp_valid) begin
        rk = k; got_err = rsp_err;
      end else begin
        if (stale && k == 0) xfer_done = 1'b0;
        if (k == dly) xfer_done = 1'b1;
        @(negedge clk);
      end
    end
    chk({tag, ".rsp_cycle"}, 32'(rk), 32'(exp_k));
    chk({tag, ".rsp_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, ".rd_cycles"}, 32'(n_rd), (legal && !dir) ? H : 0);
    chk({tag, ".wr_cycles"}, 32'(n_wr), (legal && dir) ? H : 0);
    chk({tag, ".len_stable"}, 32'(len_bad), 32'd0);
    chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      cmd_valid = 1'b1; cmd_dir = ~dir; cmd_len = 10'd4;
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_err !== exp_err
          || xfer_len !== l10 || xfer_read || xfer_write)
        hold_bad++;
    end
    if (rdy_dly > 0) chk({tag, ".hold"}, 32'(hold_bad), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    xfer_done = 1'b0;
    chk({tag, ".release"}, {29'd0, rsp_valid, cmd_ready, busy},
        32'b010);
  endtask

  initial begin
    int d, l, r;
    logic dr;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_len = '0; xfer_done = 1'b0; rsp_ready = 1'b0;
    #3;
    chk("rst.ctrl", {27'd0, xfer_read, xfer_write, rsp_valid,
        busy, cmd_ready}, 32'b00001);
    chk("rst.len", 32'(xfer_len), 32'd0);
    chk("rst.err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_xfer(1'b0, 512, 1800, 1'b0, 0, "rd512");
    run_xfer(1'b1, 2, 10, 1'b1, 0, "wr2_stale");
    run_xfer(1'b0, 0, -1, 1'b0, 0, "bad0");
    run_xfer(1'b1, 3, -1, 1'b0, 2, "bad3");
    run_xfer(1'b0, 514, -1, 1'b0, 0, "bad514");
    run_xfer(1'b1, 1023, -1, 1'b0, 0, "bad1023");
    run_xfer(1'b0, 64, -1, 1'b0, 0, "tmo");
    run_xfer(1'b1, 128, T - 2, 1'b0, 50, "tie");
    run_xfer(1'b0, 64, T - 1, 1'b0, 0, "late");
    run_xfer(1'b1, 512, 2, 1'b0, 1, "edge_last_hold");
    run_xfer(1'b0, 2, 0, 1'b0, 0, "early_done");

    // reset pulse while waiting for done
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 10'd64;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst.ctrl", {27'd0, xfer_read, xfer_write, rsp_valid,
        busy, cmd_ready}, 32'b00001);
    chk("mid_rst.len", 32'(xfer_len), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_xfer(1'b0, 256, 20, 1'b0, 1, "post_rst");

    for (int i = 0; i < 30; i++) begin
      dr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0)
        l = 2 * $urandom_range(1, 256);
      else
        l = $urandom_range(0, 1023);
      d = $urandom_range(0, 40);
      r = $urandom_range(0, 3);
      run_xfer(dr, l, d, 1'b0, r, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
